// File: rtl/logic_seq_pkg.sv
// Shared encodings and defaults for the logic-unit sequencer.
// Imported by logic_slice and logic_unit_sequencer.
package logic_seq_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SLICE = 4;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise unit; the only datapath gates in the sequencer.
module logic_slice
   import logic_seq_pkg::*;
#(
   parameter int SLICE = DEF_SLICE
) (
   input  logic [1:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = ~(a & b);
      endcase
   end

endmodule

// File: rtl/logic_unit_sequencer.sv
// Two-requester arbiter feeding WIDTH-bit bitwise ops through one SLICE-bit unit, LSB slice first.
// Optional zero flag accumulator enabled by macro LOGIC_SEQ_ZERO_FLAG_EN.
module logic_unit_sequencer
   import logic_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero
);

   localparam int BEATS  = WIDTH / SLICE;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   state_t            state_reg, state_next;
   logic              rr_ptr_reg, rr_ptr_next;
   logic [BEAT_W-1:0] beat_reg, beat_next;
   logic [1:0]        op_reg, op_next;
   logic [WIDTH-1:0]  a_reg, a_next;
   logic [WIDTH-1:0]  b_reg, b_next;
   logic [WIDTH-1:0]  result_reg, result_next;
   logic              id_reg, id_next;
   logic              grant0, grant1;
   logic [SLICE-1:0]  a_slices [BEATS];
   logic [SLICE-1:0]  b_slices [BEATS];
   logic [SLICE-1:0]  slice_y;

   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_split
         assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
         assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
      end
   endgenerate

   logic_slice #(.SLICE(SLICE)) u_slice (
      .op (op_reg),
      .a  (a_slices[beat_reg]),
      .b  (b_slices[beat_reg]),
      .y  (slice_y)
   );

   // Grants are masked during reset so ready reads 0 while rst is held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_reg == IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~rr_ptr_reg;
            grant1 = rr_ptr_reg;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      beat_next   = beat_reg;
      op_next     = op_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      result_next = result_reg;
      id_next     = id_reg;
      case (state_reg)
         IDLE: begin
            if (grant0 || grant1) begin
               op_next     = grant1 ? req1_op : req0_op;
               a_next      = grant1 ? req1_a  : req0_a;
               b_next      = grant1 ? req1_b  : req0_b;
               id_next     = grant1;
               result_next = '0;
               beat_next   = '0;
               state_next  = RUN;
            end
         end
         RUN: begin
            result_next[beat_reg*SLICE +: SLICE] = slice_y;
            if (beat_reg == LAST_BEAT) begin
               state_next = DONE;
            end else begin
               beat_next = beat_reg + 1'b1;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               rr_ptr_next = ~id_reg;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= 1'b0;
         beat_reg   <= '0;
         op_reg     <= OP_AND;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         id_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         beat_reg   <= beat_next;
         op_reg     <= op_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         result_reg <= result_next;
         id_reg     <= id_next;
      end
   end

`ifdef LOGIC_SEQ_ZERO_FLAG_EN
   logic zero_acc_reg, zero_acc_next;

   always_comb begin
      zero_acc_next = zero_acc_reg;
      if (state_reg == IDLE && (grant0 || grant1)) begin
         zero_acc_next = 1'b1;
      end else if (state_reg == RUN) begin
         zero_acc_next = zero_acc_reg & (slice_y == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_acc_reg <= 1'b0;
      end else begin
         zero_acc_reg <= zero_acc_next;
      end
   end

   assign rsp_zero = (state_reg == DONE) && zero_acc_reg;
`else
   assign rsp_zero = 1'b0;
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp_valid  = (state_reg == DONE);
   assign rsp_id     = id_reg;
   assign rsp_data   = result_reg;

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_logic_unit_sequencer;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int BEATS = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [1:0]       req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [WIDTH-1:0] rsp_data;

   always #5 clk = ~clk;

   logic_unit_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Transaction-level model: busy flag, cycles since accept, round-robin pointer, expected result.
   bit               m_busy = 1'b0;
   int               m_k    = 0;
   bit               m_rr   = 1'b0;
   bit               m_id   = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   int               cyc    = 0;

   logic [WIDTH-1:0] got_data_q [$];
   bit               got_id_q   [$];
   bit               got_zero_q [$];
   int               acc_cyc_q  [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   function automatic bit ref_zero(input logic [WIDTH-1:0] d);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
      return (d == '0);
`else
      return 1'b0;
`endif
   endfunction

   // One clock cycle: inputs already applied at the falling edge; sample, compare, advance model.
   task automatic step();
      bit g0, g1, ev, acc0, acc1;
      #1;
      ev = m_busy && (m_k >= BEATS + 1);
      g0 = 1'b0;
      g1 = 1'b0;
      if (!m_busy) begin
         if (req0_valid && req1_valid) begin
            g0 = !m_rr;
            g1 = m_rr;
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
      end
      check("req0_ready", 32'(req0_ready), 32'(g0));
      check("req1_ready", 32'(req1_ready), 32'(g1));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
         check("rsp_data", 32'(rsp_data), 32'(m_data));
         check("rsp_id", 32'(rsp_id), 32'(m_id));
         check("rsp_zero", 32'(rsp_zero), 32'(ref_zero(m_data)));
      end
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (m_busy) begin
         if (ev && rsp_ready) begin
            m_busy = 1'b0;
            m_rr   = !m_id;
            got_data_q.push_back(rsp_data);
            got_id_q.push_back(rsp_id);
            got_zero_q.push_back(rsp_zero);
            $display("[TB] cycle %0d rsp id=%0d data=%04h zero=%0d", cyc, rsp_id, rsp_data, rsp_zero);
         end else begin
            m_k++;
         end
      end else if (g0 || g1) begin
         m_busy = 1'b1;
         m_k    = 1;
         m_id   = g1;
         m_data = g1 ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
         acc_cyc_q.push_back(cyc);
      end
      cyc++;
      @(negedge clk);
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_req1_ready", 32'(req1_ready), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      m_busy = 1'b0;
      m_rr   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((m_busy || req0_valid || req1_valid) && n < maxc) begin
         step();
         n++;
      end
      check("drain_timeout", 32'(m_busy || req0_valid || req1_valid), 32'd0);
   endtask

   task automatic clear_q();
      got_data_q.delete();
      got_id_q.delete();
      got_zero_q.delete();
      acc_cyc_q.delete();
   endtask

   task automatic set_req0(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
   endtask

   task automatic set_req1(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b1;

      // Both requesters valid from reset: rr_ptr=0 so req0 first, then req1.
      set_req0(2'b10, 16'hFFFF, 16'h0F0F);
      set_req1(2'b01, 16'h1200, 16'h0034);
      @(negedge clk);
      do_reset();
      clear_q();
      drain(40);
      check("t2_count", 32'(got_data_q.size()), 32'd2);
      if (got_data_q.size() >= 2) begin
         check("t2_first_data", 32'(got_data_q[0]), 32'h0000F0F0);
         check("t2_first_id", 32'(got_id_q[0]), 32'd0);
         check("t2_second_data", 32'(got_data_q[1]), 32'h00001234);
         check("t2_second_id", 32'(got_id_q[1]), 32'd1);
      end

      // Single AND; response latency is enforced by the model every cycle.
      clear_q();
      set_req0(2'b00, 16'hAAAA, 16'hAAA5);
      drain(20);
      if (got_data_q.size() >= 1) begin
         check("t1_data", 32'(got_data_q[0]), 32'h0000AAA0);
         check("t1_id", 32'(got_id_q[0]), 32'd0);
      end else begin
         check("t1_count", 32'(got_data_q.size()), 32'd1);
      end

      // Zero result.
      clear_q();
      set_req0(2'b00, 16'hF0F0, 16'h0F0F);
      drain(20);
      if (got_data_q.size() >= 1) begin
         check("t5_data", 32'(got_data_q[0]), 32'd0);
         check("t5_zero", 32'(got_zero_q[0]), 32'(ref_zero(16'h0000)));
      end else begin
         check("t5_count", 32'(got_data_q.size()), 32'd1);
      end

      // Backpressure: stall in DONE for 10 cycles with both requesters pending.
      clear_q();
      rsp_ready = 1'b0;
      set_req0(2'b01, 16'h1234, 16'h8001);
      n = 0;
      while (!(m_busy && m_k >= BEATS + 1) && n < 20) begin
         step();
         n++;
      end
      check("t3_reach_done", 32'(rsp_valid), 32'd1);
      set_req0(2'b10, 16'h5555, 16'h00FF);
      set_req1(2'b00, 16'hFFFF, 16'h1111);
      repeat (10) step();
      check("t3_no_handoff", 32'(got_data_q.size()), 32'd0);
      // Reset while holding a response must drop rsp_valid at once.
      do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;

      // Reset mid-RUN at beat 2: aborted request never responds.
      clear_q();
      set_req0(2'b00, 16'h1234, 16'h5678);
      step();
      step();
      step();
      do_reset();
      set_req1(2'b11, 16'h0000, 16'h0000);
      drain(20);
      check("t4_count", 32'(got_data_q.size()), 32'd1);
      if (got_data_q.size() >= 1) begin
         check("t4_data", 32'(got_data_q[0]), 32'h0000FFFF);
         check("t4_id", 32'(got_id_q[0]), 32'd1);
      end

      // Lone requester: three back-to-back ops at the minimum issue interval.
      clear_q();
      n = 0;
      while ((acc_cyc_q.size() < 3 || m_busy) && n < 60) begin
         if (!req1_valid && acc_cyc_q.size() < 3)
            set_req1(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
         step();
         n++;
      end
      check("t6_accepts", 32'(acc_cyc_q.size()), 32'd3);
      if (acc_cyc_q.size() >= 3) begin
         check("t6_gap1", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'(BEATS + 2));
         check("t6_gap2", 32'(acc_cyc_q[2] - acc_cyc_q[1]), 32'(BEATS + 2));
      end

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 600; i++) begin
         if (!req0_valid && ($urandom_range(0, 2) == 0))
            set_req0(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
         if (!req1_valid && ($urandom_range(0, 2) == 0))
            set_req1(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
         if ($urandom_range(0, 7) == 0) begin
            req0_op = 2'($urandom_range(0, 3));
            req0_a  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            req0_b  = 16'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rsp_ready = 1'b1;
      drain(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
